// File: rtl/shift_left_sched_if.sv
// -----------------------------------------------------------------------------
// shift_left_sched_if
//
// Bundles the request, result and status signals of shift_left_sched.
//
//   Req_valid    [1:0]        request valid, bit i = requester i
//   Req_ready    [1:0]        request accepted when Req_valid[i] & Req_ready[i]
//   Req_data     [2*SIZE-1:0] sign-magnitude operand, requester i at [i*SIZE +: SIZE]
//   Req_shift    [2*W-1:0]    bit-position code, requester i at [i*W +: W]
//   Req_check    [1:0]        0 forces a zero result for that requester
//   Res_valid                 result valid, held until taken
//   Res_ready                 consumer accepts the result
//   Res_data     [SIZE-1:0]   shifted result
//   Res_id                    requester that owns Res_data
//   Res_overflow              a 1 was shifted out of the magnitude field
//   Busy                      scheduler is shifting or holding a result
//
// Modports:
//   master - requesters plus result consumer (drives requests, takes results)
//   slave  - the scheduler itself
// -----------------------------------------------------------------------------
interface shift_left_sched_if #(
  parameter int SIZE = 32,
  parameter int W    = $clog2(SIZE)
);

  logic [1:0]        Req_valid;
  logic [1:0]        Req_ready;
  logic [2*SIZE-1:0] Req_data;
  logic [2*W-1:0]    Req_shift;
  logic [1:0]        Req_check;

  logic              Res_valid;
  logic              Res_ready;
  logic [SIZE-1:0]   Res_data;
  logic              Res_id;
  logic              Res_overflow;

  logic              Busy;

  modport master (
    output Req_valid, Req_data, Req_shift, Req_check, Res_ready,
    input  Req_ready, Res_valid, Res_data, Res_id, Res_overflow, Busy
  );

  modport slave (
    input  Req_valid, Req_data, Req_shift, Req_check, Res_ready,
    output Req_ready, Res_valid, Res_data, Res_id, Res_overflow, Busy
  );

endinterface

// File: rtl/shift_left_sched.sv
// -----------------------------------------------------------------------------
// shift_left_sched
//
// Round-robin scheduler sharing one serial fixed-point left-shift datapath
// between two requesters. Each request carries a sign-magnitude
// Q(SIZE/2).(SIZE/2) operand, a bit-position code and a check flag. The
// magnitude is shifted left one bit per cycle (zero fill, sign untouched),
// and the result is returned with the requester id and a sticky overflow
// flag that records any 1 shifted out of the magnitude field.
//
// Shift amount n = Req_shift - SIZE/2. A code below SIZE/2 yields a zero
// magnitude with the sign kept; check = 0 yields an all-zero result. Both
// special cases finish with n = 0.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous active-low reset
//   bus    shift_left_sched_if.slave (request, result and Busy signals)
//
// Parameters SIZE and W must match the ones the interface is built with.
// -----------------------------------------------------------------------------
module shift_left_sched #(
  parameter int SIZE = 32,
  parameter int W    = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_left_sched_if.slave     bus
);

  localparam logic [W-1:0] HALF = W'(SIZE / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Datapath state. The sign and magnitude are kept apart so that the sign
  // never takes part in the shift.
  logic            sign_q;
  logic [SIZE-2:0] mag_q;
  logic [W-1:0]    cnt_q;
  logic            id_q;
  logic            ovf_q;
  logic            last_q;   // requester granted most recently

  // Arbitration / request decode
  logic            win;
  logic [1:0]      grant;
  logic            accept;
  logic [SIZE-1:0] sel_data;
  logic [W-1:0]    sel_shift;
  logic            sel_check;
  logic            in_range;
  logic            sign_in;
  logic [SIZE-2:0] mag_in;
  logic [W-1:0]    n_in;

  // ---------------------------------------------------------------------------
  // Next-state, arbitration and request decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    win       = 1'b0;
    grant     = 2'b00;
    accept    = 1'b0;
    sel_data  = '0;
    sel_shift = '0;
    sel_check = 1'b0;
    in_range  = 1'b0;
    sign_in   = 1'b0;
    mag_in    = '0;
    n_in      = '0;

    // On a tie the requester not granted last wins; otherwise the lone
    // valid requester wins.
    if (&bus.Req_valid) begin
      win = ~last_q;
    end else if (bus.Req_valid[0]) begin
      win = 1'b0;
    end else begin
      win = 1'b1;
    end

    if (state_q == IDLE) begin
      grant[0] = bus.Req_valid[0] & ~win;
      grant[1] = bus.Req_valid[1] &  win;
    end
    accept = |grant;

    // Operand of the winning requester
    if (win) begin
      sel_data  = bus.Req_data[SIZE +: SIZE];
      sel_shift = bus.Req_shift[W +: W];
      sel_check = bus.Req_check[1];
    end else begin
      sel_data  = bus.Req_data[0 +: SIZE];
      sel_shift = bus.Req_shift[0 +: W];
      sel_check = bus.Req_check[0];
    end

    in_range = (sel_shift >= HALF);
    sign_in  = sel_check & sel_data[SIZE-1];
    if (sel_check && in_range) begin
      mag_in = sel_data[SIZE-2:0];
      n_in   = sel_shift - HALF;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (n_in == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // The counter holds the shifts still to do, including this cycle's.
        if (cnt_q == W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.Res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and arbitration pointer
  // ---------------------------------------------------------------------------
  // NOTE: every datapath register is reset, not only the control state,
  // because the result fields are visible on the outputs and must read 0
  // after reset; a reset mid-operation also discards the partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
      cnt_q  <= '0;
      id_q   <= 1'b0;
      ovf_q  <= 1'b0;
      last_q <= 1'b1;
    end else if (accept) begin
      sign_q <= sign_in;
      mag_q  <= mag_in;
      cnt_q  <= n_in;
      id_q   <= win;
      ovf_q  <= 1'b0;
      last_q <= win;
    end else if (state_q == SHIFT) begin
      mag_q  <= {mag_q[SIZE-3:0], 1'b0};
      ovf_q  <= ovf_q | mag_q[SIZE-2];
      cnt_q  <= cnt_q - W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Req_ready    = grant;
  assign bus.Res_valid    = (state_q == DONE);
  assign bus.Res_data     = {sign_q, mag_q};
  assign bus.Res_id       = id_q;
  assign bus.Res_overflow = ovf_q;
  assign bus.Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_shift_left_sched.sv
// -----------------------------------------------------------------------------
// tb_shift_left_sched
//
// Directed bench for shift_left_sched: reset values, single jobs with
// hand-computed results and latencies, round-robin alternation, result
// back-pressure, check = 0 forcing, and asynchronous reset mid-shift.
// -----------------------------------------------------------------------------
module tb_shift_left_sched;

  localparam int SIZE = 32;
  localparam int W    = $clog2(SIZE);

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  shift_left_sched_if #(.SIZE(SIZE), .W(W)) bus ();

  shift_left_sched #(.SIZE(SIZE), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to a point 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [SIZE-1:0] d,
                         input logic [W-1:0] s, input logic c);
    bus.Req_data[idx*SIZE +: SIZE] = d;
    bus.Req_shift[idx*W +: W]      = s;
    bus.Req_check[idx]             = c;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 64'(bus.Req_ready),    64'd0);
    check({tag, "_res_valid"}, 64'(bus.Res_valid),    64'd0);
    check({tag, "_res_data"},  64'(bus.Res_data),     64'd0);
    check({tag, "_res_id"},    64'(bus.Res_id),       64'd0);
    check({tag, "_res_ovf"},   64'(bus.Res_overflow), 64'd0);
    check({tag, "_busy"},      64'(bus.Busy),         64'd0);
  endtask

  // One job from a single requester, taken immediately when it is valid.
  task automatic run_job(input string tag, input int idx,
                         input logic [SIZE-1:0] d, input logic [W-1:0] s,
                         input logic c, input int exp_lat,
                         input logic [SIZE-1:0] exp_data, input logic exp_ovf);
    int lat;
    set_req(idx, d, s, c);
    bus.Req_valid = 2'b00;
    bus.Req_valid[idx] = 1'b1;
    #1;
    check({tag, "_ready"}, 64'(bus.Req_ready), 64'(bus.Req_valid));
    tick();
    bus.Req_valid = 2'b00;
    #1;
    lat = 0;
    while (!bus.Res_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  64'(lat),              64'(exp_lat));
    check({tag, "_data"}, 64'(bus.Res_data),     64'(exp_data));
    check({tag, "_id"},   64'(bus.Res_id),       64'(idx));
    check({tag, "_ovf"},  64'(bus.Res_overflow), 64'(exp_ovf));
    bus.Res_ready = 1'b1;
    tick();
    bus.Res_ready = 1'b0;
    #1;
    check({tag, "_idle"}, 64'({bus.Res_valid, bus.Busy}), 64'd0);
  endtask

  initial begin
    int gidx;
    int last_c;
    logic exp_id;

    n_cmp = 0;
    n_bad = 0;
    rst_n         = 1'b0;
    bus.Req_valid = 2'b00;
    bus.Req_data  = '0;
    bus.Req_shift = '0;
    bus.Req_check = 2'b00;
    bus.Res_ready = 1'b0;

    #12;
    check_reset("por");
    rst_n = 1'b1;
    tick();

    // n = 3: 0x0001_8000 << 3 on the magnitude
    run_job("j0", 0, 32'h0001_8000, 5'd19, 1'b1, 3, 32'h000C_0000, 1'b0);
    // n = 1, sign kept
    run_job("j1", 1, 32'h8001_0000, 5'd17, 1'b1, 1, 32'h8002_0000, 1'b0);
    // bit 30 shifted out of the magnitude
    run_job("j2", 0, 32'h4000_0000, 5'd17, 1'b1, 1, 32'h0000_0000, 1'b1);
    // code below SIZE/2: zero magnitude, positive sign, overflow cleared
    run_job("j3", 0, 32'h1234_5678, 5'd10, 1'b1, 0, 32'h0000_0000, 1'b0);

    // Round robin: both valid, n = 0, results taken immediately.
    // Last grant was requester 0, but j0..j3 leave the pointer at 0, so the
    // first tie goes to requester 1? No: reset the pointer history by
    // relying only on relative alternation starting from the next winner.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    set_req(0, 32'h0000_0011, 5'd16, 1'b1);
    set_req(1, 32'h8000_0022, 5'd16, 1'b1);
    bus.Res_ready = 1'b1;
    bus.Req_valid = 2'b11;
    #1;
    gidx   = 0;
    last_c = -1;
    exp_id = 1'b0;
    for (int c = 0; c < 14 && gidx < 5; c++) begin
      if (bus.Req_ready != 2'b00) begin
        check("rr_grant", 64'(bus.Req_ready), (gidx % 2 == 0) ? 64'd1 : 64'd2);
        if (gidx > 0) begin
          check("rr_gap", 64'(c - last_c), 64'd2);
        end
        exp_id = (gidx % 2 == 1);
        last_c = c;
        gidx++;
      end else if (bus.Res_valid) begin
        check("rr_id",   64'(bus.Res_id),   64'(exp_id));
        check("rr_data", 64'(bus.Res_data), exp_id ? 64'h8000_0022 : 64'h0000_0011);
      end
      tick();
    end
    check("rr_count", 64'(gidx), 64'd5);
    bus.Req_valid = 2'b00;
    tick();
    bus.Res_ready = 1'b0;
    #1;
    check("rr_idle", 64'(bus.Busy), 64'd0);

    // check = 0 forces zero; result held under back-pressure.
    set_req(1, 32'hFFFF_FFFF, 5'd31, 1'b0);
    bus.Req_valid = 2'b10;
    #1;
    check("chk0_ready", 64'(bus.Req_ready), 64'd2);
    tick();
    bus.Req_valid = 2'b00;
    set_req(0, 32'h0000_0001, 5'd16, 1'b1);
    bus.Req_valid[0] = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("chk0_valid", 64'(bus.Res_valid),    64'd1);
      check("chk0_data",  64'(bus.Res_data),     64'd0);
      check("chk0_id",    64'(bus.Res_id),       64'd1);
      check("chk0_ovf",   64'(bus.Res_overflow), 64'd0);
      check("chk0_hold",  64'(bus.Req_ready),    64'd0);
      tick();
    end
    bus.Req_valid = 2'b00;
    bus.Res_ready = 1'b1;
    tick();
    bus.Res_ready = 1'b0;
    #1;
    check("chk0_idle", 64'(bus.Busy), 64'd0);

    // Asynchronous reset five cycles into a 15-cycle shift.
    set_req(0, 32'h7FFF_FFFF, 5'd31, 1'b1);
    bus.Req_valid = 2'b01;
    #1;
    check("rst_accept", 64'(bus.Req_ready), 64'd1);
    tick();
    bus.Req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check("rst_busy",   64'(bus.Busy),      64'd1);
    check("rst_noacc",  64'(bus.Req_ready), 64'd0);
    bus.Req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    tick();
    rst_n = 1'b1;
    #1;
    // Lone requester 1 wins; a tie then goes to requester 0.
    bus.Req_valid = 2'b10;
    #1;
    check("post_r1", 64'(bus.Req_ready), 64'd2);
    bus.Req_valid = 2'b00;
    #1;
    check("post_none", 64'(bus.Req_ready), 64'd0);
    set_req(0, 32'h0000_0005, 5'd16, 1'b1);
    bus.Req_valid = 2'b11;
    #1;
    check("post_tie", 64'(bus.Req_ready), 64'd1);
    tick();
    bus.Req_valid = 2'b00;
    #1;
    check("post_valid", 64'(bus.Res_valid), 64'd1);
    check("post_id",    64'(bus.Res_id),    64'd0);
    check("post_data",  64'(bus.Res_data),  64'h0000_0005);
    bus.Res_ready = 1'b1;
    tick();
    bus.Res_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_left_sched.md
# shift_left_sched

Round-robin scheduler that shares one serial fixed-point left-shift datapath between two requesters. Each request carries a sign-magnitude Q(SIZE/2).(SIZE/2) operand, a bit-position code, and a check flag. The block applies the team's fixed-point shift-left convention one bit per cycle, then returns the result with the requester ID and an overflow flag. It sits between the normalisation stages of the arithmetic pipeline and frees them from owning a barrel shifter each.

## Interface
- SIZE, 32: operand/result width; bit SIZE-1 is the sign, SIZE-2:0 is the magnitude.
- W, $clog2(SIZE): width of one Bit_shift code.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Req_valid  in  2  request valid, bit i = requester i.
- Req_ready  out  2  request accepted when Req_valid[i] & Req_ready[i].
- Req_data  in  2*SIZE  operand; requester i at [i*SIZE +: SIZE].
- Req_shift  in  2*W  bit-position code; requester i at [i*W +: W].
- Req_check  in  2  0 forces a zero result.
- Res_valid  out  1  result valid; held until taken.
- Res_ready  in  1  consumer accepts result.
- Res_data  out  SIZE  shifted result.
- Res_id  out  1  requester that owns Res_data.
- Res_overflow  out  1  a 1 was shifted out of the magnitude field.
- Busy  out  1  high in SHIFT or DONE.

## Operation
- Shift amount: n = Req_shift − SIZE/2 when Req_shift ≥ SIZE/2.
- Special cases:
  - Req_shift < SIZE/2: magnitude result is 0, sign kept, overflow 0, n treated as 0.
  - Req_check = 0: Res_data = 0 (sign also 0), overflow 0, n treated as 0.
- The sign bit never shifts. The magnitude shifts left one bit per SHIFT cycle, zero-filled. Overflow is the sticky OR of every magnitude bit [SIZE-2] shifted out.
- FSM states:
  - IDLE: grant per arbitration below. On accept, latch operand, sign, n, id and clear overflow. Go to DONE if n = 0, else go to SHIFT with counter = n.
  - SHIFT: each cycle, shift 1 and decrement the counter. On the cycle the counter reaches 1, move to DONE.
  - DONE: Res_valid = 1. On Res_ready, go to IDLE.
- Arbitration, evaluated only in IDLE:
  - Req_ready is combinational: Req_ready[i] = 1 iff in IDLE, Req_valid[i] = 1, and i is the winner.
  - Both requesters valid: the winner is the requester not granted last.
  - Only one valid: that requester wins.
  - The last-grant pointer updates only on accept.
- Req_ready is 0 outside IDLE. A requester must hold Req_valid and its data stable until accepted.
- Res_data, Res_id and Res_overflow are stable while Res_valid = 1.

## Timing
- Reset values (asynchronous on rst_n low):
  - state IDLE
  - Req_ready 0, Res_valid 0, Res_data 0, Res_id 0, Res_overflow 0, Busy 0
  - last-grant pointer 1, so requester 0 wins the first tie.
- Latency: with the accept on edge E0, Res_valid is high after edge E0+n, where n is 0..SIZE/2−1. An n = 0 result is visible in the cycle after the accept.
- DONE→IDLE on the edge where Res_valid & Res_ready. The next accept can happen no earlier than the following edge, so there is no same-cycle result-take and new accept. Throughput is one request per n+2 cycles.
- Res_ready low in DONE: hold indefinitely with no state change.
- Reset mid-SHIFT or mid-DONE: the in-flight result is discarded and the block returns to the reset values. No partial result is emitted.
- Req_valid dropping in IDLE before accept is legal; no grant occurs.

## Test plan
- Req0 data 0x0001_8000, shift 19, check 1 → Req_ready[0] in the same cycle; Res_valid 3 cycles after the accept edge; Res_data 0x000C_0000, id 0, overflow 0.
- Req1 data 0x8001_0000, shift 17 → Res_data 0x8002_0000 (sign kept), id 1, latency 1.
- Req0 data 0x4000_0000, shift 17 → Res_data 0x0000_0000, overflow 1. Then req0 data 0x1234_5678, shift 10 → Res_data 0x0000_0000, overflow 0, latency 0.
- Both valid continuously with shift 16, Res_ready tied high:
  - first grant is 0, then grants alternate 1, 0, 1, 0;
  - a new accept occurs every 2 cycles.
- Check = 0 with data 0xFFFF_FFFF, shift 31 → Res_data 0, Res_valid right after accept. With Res_ready held low for 5 cycles, the outputs stay stable and Req_ready stays 0.
- Assert rst_n low during SHIFT, with shift 31 and 5 cycles in → all outputs return to their reset values asynchronously. After release, a pending req1 is granted first only if req0 is idle; if both are valid, req0 wins.
